// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-port control.
//   DATA_W   : register data width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
package rf_ctrl_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus between the writeback requesters / issue / decode stages and the
// register-file write-port arbiter.
//   req_valid/req_addr/req_data/req_ready : writeback requester handshake
//   rf_wena/rf_waddr/rf_wdata            : registered register-file write port
//   alloc_valid/alloc_addr               : issue-stage destination allocation
//   chk0/1_addr, chk0/1_busy, busy_vec   : decode hazard queries
// The slave modport is the arbiter; master is the surrounding pipeline.
interface rf_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = rf_ctrl_pkg::DATA_W,
    parameter int ADDR_W  = rf_ctrl_pkg::ADDR_W
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      rf_wena;
    logic [ADDR_W-1:0]         rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;

    logic                      alloc_valid;
    logic [ADDR_W-1:0]         alloc_addr;
    logic [ADDR_W-1:0]         chk0_addr;
    logic [ADDR_W-1:0]         chk1_addr;
    logic                      chk0_busy;
    logic                      chk1_busy;
    logic [NUM_REGS-1:0]       busy_vec;

    modport slave (
        input  req_valid, req_addr, req_data, alloc_valid, alloc_addr, chk0_addr, chk1_addr,
        output req_ready, rf_wena, rf_waddr, rf_wdata, chk0_busy, chk1_busy, busy_vec
    );

    modport master (
        output req_valid, req_addr, req_data, alloc_valid, alloc_addr, chk0_addr, chk1_addr,
        input  req_ready, rf_wena, rf_waddr, rf_wdata, chk0_busy, chk1_busy, busy_vec
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle (must be < NUM_REQ)
//   grant_o : one-hot grant, zero when no request
// Requests are rotated so ptr_i lands on bit 0, the lowest set bit is
// isolated, and the result is rotated back.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);
    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0] gnt_rot;
    int                 src;

    always_comb begin
        req_rot = '0;
        gnt_rot = '0;
        grant_o = '0;
        src     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            src = k + int'(ptr_i);
            if (src >= NUM_REQ) src = src - NUM_REQ;
            req_rot[k] = req_i[src];
        end
        // x & -x keeps only the lowest set bit
        gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
        for (int k = 0; k < NUM_REQ; k++) begin
            src = k + int'(ptr_i);
            if (src >= NUM_REQ) src = src - NUM_REQ;
            grant_o[src] = gnt_rot[k];
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin sharing of the register-file write port between NUM_REQ
// writeback requesters, with a registered write stage and a per-register
// pending scoreboard for decode hazard detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rf_wb_arbiter_if slave (requesters, RF write, alloc, checks)
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = rf_ctrl_pkg::DATA_W,
    parameter int ADDR_W  = rf_ctrl_pkg::ADDR_W
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int PTR_W    = $clog2(NUM_REQ);

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                wena_q, wena_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0]  grant_raw, grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_raw)
    );

    // No grants may escape while reset is held, even with requests pending.
    assign grant = rst_n ? grant_raw : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wena_d   = |grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                rr_ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                waddr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
                wdata_d  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Clear first, then set: a same-register allocation overrides the
    // landing write because a newer producer is now outstanding.
    always_comb begin
        pending_d = pending_q;
        if (wena_q)          pending_d[waddr_q]        = 1'b0;
        if (bus.alloc_valid) pending_d[bus.alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wena_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wena_q    <= wena_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rf_wena   = wena_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;

    // Registered view only: a register stays busy during its rf_wena cycle.
    assign bus.chk0_busy = pending_q[bus.chk0_addr];
    assign bus.chk1_busy = pending_q[bus.chk1_addr];
    assign bus.busy_vec  = pending_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    import rf_ctrl_pkg::*;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int        stamp;
        reg_addr_t addr;
        reg_data_t data;
    } wr_t;

    wr_t          exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           mdl_ptr = 0;
    logic [N-1:0] exp_gnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Output-stage scoreboard: a write predicted in cycle C must appear on
    // the RF port during cycle C+1 and nowhere else.
    always @(negedge clk) begin
        if (rst_n) begin
            wr_t e;
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc - 1) begin
                n_tests++; n_fail++;
                $display("FAIL wb_missing: write to r%0d never appeared", exp_q[0].addr);
                void'(exp_q.pop_front());
            end
            n_tests++;
            if (exp_q.size() > 0 && exp_q[0].stamp == cyc - 1) begin
                e = exp_q.pop_front();
                if (bus.rf_wena !== 1'b1 || bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL wb_data: got wena=%b addr=%0d data=%h expected wena=1 addr=%0d data=%h",
                             bus.rf_wena, bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
                end
            end else if (bus.rf_wena !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_spurious: got wena=%b expected 0", bus.rf_wena);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.alloc_valid = 1'b0;
        bus.alloc_addr  = '0;
        bus.chk0_addr   = '0;
        bus.chk1_addr   = '0;
    endtask

    task automatic set_req(input int i, input logic v, input reg_addr_t a, input reg_data_t d);
        bus.req_valid[i]                = v;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int ptr);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (v[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Predict this cycle's grant and queue the resulting write.
    task automatic model_issue();
        exp_gnt = model_grant(bus.req_valid, mdl_ptr);
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) begin
                exp_q.push_back('{cyc, bus.req_addr[i*ADDR_W +: ADDR_W], bus.req_data[i*DATA_W +: DATA_W]});
                mdl_ptr = (i + 1) % N;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        mdl_ptr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            n_tests++;
            if (bus.rf_wena !== 1'b0 || bus.req_ready !== 3'b000 || bus.busy_vec !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got wena=%b ready=%b busy=%h expected 0/000/0000",
                         bus.rf_wena, bus.req_ready, bus.busy_vec);
            end
        end
        bus.req_valid = '0;
        rst_n = 1'b1;
        mdl_ptr = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_tests++;
            if (bus.rf_wena !== 1'b0 || bus.req_ready !== 3'b000 || bus.busy_vec !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_idle: got wena=%b ready=%b busy=%h expected 0/000/0000",
                         bus.rf_wena, bus.req_ready, bus.busy_vec);
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 4'd5, 64'hDEAD_BEEF_0000_0001);
        model_issue();
        settle();
        n_tests++;
        if (bus.req_ready !== 3'b010 || bus.req_ready !== exp_gnt) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 010", bus.req_ready);
        end
        next_cycle();
        set_req(1, 1'b0, '0, '0);
        settle();
        n_tests++;
        if (bus.rf_wena !== 1'b1 || bus.rf_waddr !== 4'd5 || bus.rf_wdata !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL single_write: got wena=%b addr=%0d data=%h expected 1/5/deadbeef00000001",
                     bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] order [6];
        order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, reg_addr_t'(i + 1), {32'hA0A0_0000, 32'(i)});
        for (int c = 0; c < 6; c++) begin
            model_issue();
            settle();
            n_tests++;
            if (bus.req_ready !== order[c] || bus.req_ready !== exp_gnt) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %b expected %b", c, bus.req_ready, order[c]);
            end
            if (c > 0) begin
                n_tests++;
                if (bus.rf_waddr !== reg_addr_t'((c - 1) % N + 1)) begin
                    n_fail++;
                    $display("FAIL rr_waddr[%0d]: got %0d expected %0d", c, bus.rf_waddr, (c - 1) % N + 1);
                end
            end
            next_cycle();
            // the granted requester presents fresh data for its next write
            set_req(c % N, 1'b1, reg_addr_t'(c % N + 1), {32'hA0A0_0000 + 32'(c + 1), 32'(c % N)});
        end
        bus.req_valid = '0;
        next_cycle();
    endtask

    task automatic test_random();
        logic [N-1:0] held;
        int           wait_cnt [N];
        held = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!held[i])
                    set_req(i, 1'($urandom_range(0, 1)), reg_addr_t'($urandom), {$urandom, $urandom});
            end
            model_issue();
            settle();
            n_tests++;
            if (bus.req_ready !== exp_gnt) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got %b expected %b valid=%b", c, bus.req_ready, exp_gnt, bus.req_valid);
            end
            for (int i = 0; i < N; i++) begin
                held[i]     = bus.req_valid[i] && !exp_gnt[i];
                wait_cnt[i] = held[i] ? wait_cnt[i] + 1 : 0;
                if (wait_cnt[i] >= N) begin
                    n_tests++; n_fail++;
                    $display("FAIL fairness: requester %0d waited %0d cycles expected < %0d", i, wait_cnt[i], N);
                end
            end
            next_cycle();
        end
        bus.req_valid = '0;
        next_cycle();
    endtask

    task automatic test_scoreboard();
        do_reset();
        bus.chk0_addr   = 4'd7;
        bus.chk1_addr   = 4'd3;
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 4'd7;
        settle();
        n_tests++;
        if (bus.chk0_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_no_bypass: got %b expected 0", bus.chk0_busy);
        end
        next_cycle();
        bus.alloc_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            logic exp_b;
            exp_b = (c >= 1 && c <= 4);
            set_req(0, c == 3, 4'd7, 64'h0000_0000_7777_0003);
            if (c == 3) model_issue();
            settle();
            n_tests++;
            if (bus.chk0_busy !== exp_b || bus.chk1_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_life[%0d]: got chk0=%b chk1=%b expected chk0=%b chk1=0",
                         c, bus.chk0_busy, bus.chk1_busy, exp_b);
            end
            if (c == 1) begin
                n_tests++;
                if (bus.busy_vec !== 16'h0080) begin
                    n_fail++;
                    $display("FAIL sb_vec: got %h expected 0080", bus.busy_vec);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 4'd9;
        next_cycle();
        bus.alloc_valid = 1'b0;
        set_req(2, 1'b1, 4'd9, 64'h9999_0000_0000_0002);
        model_issue();
        settle();
        n_tests++;
        if (bus.req_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL coll_ready: got %b expected 100", bus.req_ready);
        end
        next_cycle();
        set_req(2, 1'b0, '0, '0);
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 4'd9;
        next_cycle();
        bus.alloc_valid = 1'b0;
        n_tests++;
        if (bus.busy_vec !== 16'h0200) begin
            n_fail++;
            $display("FAIL coll_same: got %h expected 0200", bus.busy_vec);
        end
        // write r9 again while allocating a different register
        set_req(0, 1'b1, 4'd9, 64'h9999_0000_0000_0000);
        model_issue();
        next_cycle();
        set_req(0, 1'b0, '0, '0);
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 4'd4;
        next_cycle();
        bus.alloc_valid = 1'b0;
        n_tests++;
        if (bus.busy_vec !== 16'h0010) begin
            n_fail++;
            $display("FAIL coll_diff: got %h expected 0010", bus.busy_vec);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.chk0_addr = 4'd5;
        for (int c = 0; c < 4; c++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_addr  = reg_addr_t'(4 + c);
            next_cycle();
        end
        bus.alloc_valid = 1'b0;
        set_req(0, 1'b1, 4'd2, 64'h0202_0202_0202_0202);
        model_issue();
        next_cycle();
        settle();
        n_tests++;
        if (bus.rf_wena !== 1'b1 || bus.busy_vec !== 16'h00F0) begin
            n_fail++;
            $display("FAIL arst_pre: got wena=%b busy=%h expected 1/00f0", bus.rf_wena, bus.busy_vec);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_tests++;
        if (bus.rf_wena !== 1'b0 || bus.busy_vec !== 16'h0 || bus.req_ready !== 3'b000 || bus.chk0_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now: got wena=%b busy=%h ready=%b chk0=%b expected 0/0000/000/0",
                     bus.rf_wena, bus.busy_vec, bus.req_ready, bus.chk0_busy);
        end
        clear_inputs();
        mdl_ptr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        n_tests++;
        if (bus.rf_wena !== 1'b0 || bus.busy_vec !== 16'h0) begin
            n_fail++;
            $display("FAIL arst_post: got wena=%b busy=%h expected 0/0000", bus.rf_wena, bus.busy_vec);
        end
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        exp_gnt = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_scoreboard();
        test_collision();
        test_async_reset();
        repeat (2) next_cycle();
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL wb_leftover: %0d writes never appeared", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 64-bit pipeline register file between NUM_REQ writeback requesters (e.g. ALU, load unit, multiplier) using round-robin arbitration.
- Registers the granted write and drives the register file's wena/waddr/wdata.
- Keeps a per-register pending scoreboard (set at issue, cleared when the write lands), so decode can stall on read-after-write hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 64, register data width.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  requester i has a write pending.
- req_addr  input  NUM_REQ*ADDR_W  destination of requester i; slice i is [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  write data of requester i; slice i is [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
- rf_wena  output  1  register file write enable (registered).
- rf_waddr  output  ADDR_W  register file write address (registered).
- rf_wdata  output  DATA_W  register file write data (registered).
- alloc_valid  input  1  issue stage marks a destination pending.
- alloc_addr  input  ADDR_W  destination being allocated.
- chk0_addr  input  ADDR_W  first decode source address.
- chk1_addr  input  ADDR_W  second decode source address.
- chk0_busy  output  1  pending[chk0_addr].
- chk1_busy  output  1  pending[chk1_addr].
- busy_vec  output  NUM_REGS  full pending scoreboard.

Behaviour:
- One clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: rr_ptr=0, rf_wena=0, rf_waddr=0, rf_wdata=0, pending=all 0.
  - While reset is asserted: req_ready=0, chk0_busy=0, chk1_busy=0, busy_vec=0.
- Arbitration is combinational in the same cycle as req_valid.
  - Search starts at index rr_ptr, then rr_ptr+1, ..., wrapping modulo NUM_REQ; the first valid requester wins.
  - req_ready is one-hot on the winner; all zeros if no requester is valid.
  - req_ready is never asserted to a requester whose req_valid is low.
- rr_ptr update:
  - On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ. Wrap at g=NUM_REQ-1 gives 0.
  - With no grant: rr_ptr holds.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Throughput and latency:
  - The output stage is a single register that is never stalled, so exactly one grant is possible per cycle.
  - Latency 1: a grant in cycle N gives rf_wena=1 with the granted address and data in cycle N+1.
  - The register file captures that write at the end of cycle N+1.
- rf_wena <= |grant every cycle.
  - rf_waddr and rf_wdata load only on a grant; otherwise they hold.
- Requesters must hold req_addr and req_data stable while req_valid=1 and not granted.
- Scoreboard, evaluated at each rising edge:
  - Set: alloc_valid=1 sets pending[alloc_addr].
  - Clear: rf_wena=1 clears pending[rf_waddr]. The clear happens at the same edge the register file writes, so a cleared bit always means the data is readable.
  - Set and clear on the same register in the same cycle: set wins (a newer producer is outstanding).
  - Set and clear on different registers in the same cycle: both take effect.
  - Writing a register that is not pending is legal; the bit stays 0.
- chk0_busy and chk1_busy are combinational reads of the registered pending bits, with no same-cycle bypass.
  - A register is still reported busy in the cycle its write is on rf_wena.
- All registers, including index 0, are writable and tracked; there is no hardwired zero register.
- Reset mid-operation: any in-flight granted write is dropped (rf_wena forced to 0) and all pending bits clear. Upstream must flush together with reset.

Decomposition:
- Shared package rf_ctrl_pkg holds:
  - DATA_W, ADDR_W and NUM_REGS constants;
  - a typedef for the register address;
  - a typedef for the register data word.
- One sub-module: rr_arbiter.
  - Parameter NUM_REQ; inputs req[NUM_REQ] and the pointer; output one-hot grant.
  - Purely combinational, with a rotate-priority-rotate structure.
- rf_wb_arbiter owns the pointer register, the output stage and the scoreboard.

Test Plan:
1. Reset then idle.
   - Stimulus: assert rst_n=0 for 3 cycles, release, req_valid=000 for 5 cycles.
   - Required: rf_wena=0, req_ready=000, busy_vec=0 throughout.
2. Single requester.
   - Stimulus: req_valid=010, req_addr[1]=5, req_data[1]=64'hDEAD_BEEF_0000_0001.
   - Required: req_ready=010 in the same cycle; next cycle rf_wena=1, rf_waddr=5, rf_wdata=64'hDEAD_BEEF_0000_0001.
3. Round-robin, all busy.
   - Stimulus: req_valid=111 held for 6 cycles after reset.
   - Required: grants in order 001,010,100,001,010,100; rf_waddr follows each granted req_addr one cycle later.
4. Scoreboard lifecycle.
   - Stimulus: alloc r7 in cycle 0; requester 0 writes r7 with grant in cycle 3.
   - Required: chk0_busy=1 for chk0_addr=7 in cycles 1-4; chk0_busy=0 from cycle 5.
5. Set/clear collision.
   - Stimulus: rf_wena=1 with rf_waddr=9 in the same cycle as alloc_valid=1 with alloc_addr=9.
   - Required: busy_vec[9]=1 after the edge.
6. Asynchronous reset mid-write.
   - Stimulus: drop rst_n between clock edges while rf_wena=1 and pending=16'h00F0.
   - Required: rf_wena=0 and busy_vec=0 immediately, without waiting for a clock edge.
